// File: rtl/npu_pkg.sv
// Shared constants and the feeder FSM state encoding for the 3x3 systolic NPU.
package npu_pkg;

  localparam int NPU_LANES    = 3;
  localparam int NPU_DWIDTH   = 8;
  localparam int NPU_ROWCNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } feed_state_e;

endpackage

// File: rtl/npu_sync_fifo.sv
// Generic single-clock show-ahead FIFO with occupancy output; writes while full are dropped.
// Read data is the head entry and is valid whenever empty_o is low.
module npu_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             full_q;
  logic             empty_q;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en_i && !full_q;
  assign do_rd = rd_en_i && !empty_q;

  always_comb begin
    level_d = level_q;
    if (do_wr && !do_rd) begin
      level_d = level_q + LW'(1);
    end else if (!do_wr && do_rd) begin
      level_d = level_q - LW'(1);
    end
  end

  // Flags are registered from the next level so they never glitch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = level_q;

endmodule

// File: rtl/npu_skew_feeder.sv
// Buffers activation rows and streams them diagonally skewed into the PE array, then drains with zero rows.
// Optional stall counter enabled by defining NPU_FEEDER_STALL_CNT_EN.
module npu_skew_feeder
  import npu_pkg::*;
#(
  parameter int LANES  = NPU_LANES,
  parameter int DWIDTH = NPU_DWIDTH,
  parameter int DEPTH  = 16,
  parameter int DRAIN  = 4
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LANES*DWIDTH-1:0]   s_data,
  input  logic                      start,
  input  logic [NPU_ROWCNT_W-1:0]   row_count,
  output logic [LANES*DWIDTH-1:0]   lane_o,
  output logic                      en_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic [15:0]               stall_cnt_o
);

  localparam int RW  = LANES * DWIDTH;
  localparam int DRW = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);

  feed_state_e             state_q, state_d;
  logic [NPU_ROWCNT_W-1:0] rows_left_q, rows_left_d;
  logic [DRW-1:0]          drain_left_q, drain_left_d;
  logic                    en_q, done_q, busy_q, done_d;
  logic                    pop, advance, stall, clr_stall;
  logic                    fifo_full, fifo_empty;
  logic [RW-1:0]           fifo_rd_data;
  logic [RW-1:0]           feed_row;

  npu_sync_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .wr_en_i   (s_valid),
    .wr_data_i (s_data),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level_o)
  );

  assign s_ready = !fifo_full;

  always_comb begin
    state_d      = state_q;
    rows_left_d  = rows_left_q;
    drain_left_d = drain_left_q;
    pop          = 1'b0;
    advance      = 1'b0;
    stall        = 1'b0;
    clr_stall    = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rows_left_d = row_count;
          clr_stall   = 1'b1;
          if (row_count != '0) begin
            state_d = ST_STREAM;
          end else begin
            state_d      = ST_DRAIN;
            drain_left_d = '0;
          end
        end
      end
      ST_STREAM: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          advance     = 1'b1;
          rows_left_d = rows_left_q - NPU_ROWCNT_W'(1);
          if (rows_left_q == NPU_ROWCNT_W'(1)) begin
            state_d      = ST_DRAIN;
            drain_left_d = DRW'(DRAIN);
          end
        end else begin
          stall = 1'b1;
        end
      end
      ST_DRAIN: begin
        // A zero drain count finishes without advancing (empty run).
        if (drain_left_q != '0) begin
          advance      = 1'b1;
          drain_left_d = drain_left_q - DRW'(1);
        end
        if (drain_left_q <= DRW'(1)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      rows_left_q  <= '0;
      drain_left_q <= '0;
      en_q         <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rows_left_q  <= rows_left_d;
      drain_left_q <= drain_left_d;
      en_q         <= advance;
      done_q       <= done_d;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign en_o   = en_q;
  assign done_o = done_q;
  assign busy_o = busy_q;

  assign feed_row = pop ? fifo_rd_data : '0;

  // Lane k is a (k+1)-deep shift register; the last stage drives the array edge.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DWIDTH-1:0] sr_q [k+1];

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        for (int j = 0; j <= k; j++) begin
          sr_q[j] <= '0;
        end
      end else if (advance) begin
        sr_q[0] <= feed_row[k*DWIDTH +: DWIDTH];
        for (int j = 1; j <= k; j++) begin
          sr_q[j] <= sr_q[j-1];
        end
      end
    end

    assign lane_o[k*DWIDTH +: DWIDTH] = sr_q[k];
  end

`ifdef NPU_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clr_stall) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_stall;
  assign unused_stall = stall ^ clr_stall;
  assign stall_cnt_o  = 16'd0;
`endif

endmodule

// File: tb/tb_npu_skew_feeder.sv
// Randomized self-checking bench for npu_skew_feeder against a queue-based reference model.
module tb_npu_skew_feeder;

  localparam int DRAIN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_data = '0;
  logic        start = 1'b0;
  logic [4:0]  row_count = '0;
  logic [23:0] lane_o;
  logic        en_o, busy_o, done_o;
  logic [4:0]  level_o;
  logic [15:0] stall_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  npu_skew_feeder dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .start       (start),
    .row_count   (row_count),
    .lane_o      (lane_o),
    .en_o        (en_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .level_o     (level_o),
    .stall_cnt_o (stall_cnt_o)
  );

  // Reference model: FIFO as a queue, skew as a history of rows fed into the array.
  logic [23:0] mq[$];
  logic [23:0] hist[$];
  int          m_mode = 0;
  int          m_left = 0;
  int          m_dleft = 0;
  int          m_stall = 0;
  bit          m_en = 0, m_done = 0, m_busy = 0;

  function automatic logic [23:0] model_lane();
    logic [23:0] r, e;
    int idx;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      idx = hist.size() - 1 - k;
      if (idx >= 0) begin
        e = hist[idx];
        r[k*8 +: 8] = e[k*8 +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [48:0] model_vec();
    logic [15:0] st;
`ifdef NPU_FEEDER_STALL_CNT_EN
    st = 16'(m_stall);
`else
    st = 16'd0;
`endif
    return {m_en, m_done, m_busy, (mq.size() < 16), 5'(mq.size()), model_lane(), st};
  endfunction

  function automatic logic [48:0] dut_vec();
    return {en_o, done_o, busy_o, s_ready, level_o, lane_o, stall_cnt_o};
  endfunction

  task automatic step();
    bit          push, adv;
    logic [23:0] fed;
    int          sz;
    sz = mq.size();
    push = s_valid && (sz < 16);
    adv = 0;
    fed = '0;
    m_done = 0;
    if (rst) begin
      mq.delete();
      hist.delete();
      m_mode = 0; m_left = 0; m_dleft = 0; m_stall = 0;
      m_en = 0; m_busy = 0;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_stall = 0;
          m_left = int'(row_count);
          if (row_count != 0) m_mode = 1;
          else begin m_mode = 2; m_dleft = 0; end
        end
        1: if (sz > 0) begin
          fed = mq.pop_front();
          adv = 1;
          m_left--;
          if (m_left == 0) begin m_mode = 2; m_dleft = DRAIN; end
        end else if (m_stall < 65535) m_stall++;
        default: begin
          if (m_dleft > 0) begin adv = 1; m_dleft--; end
          if (m_dleft == 0) begin m_done = 1; m_mode = 0; end
        end
      endcase
      if (push) mq.push_back(s_data);
      if (adv) hist.push_back(fed);
      m_en = adv;
      m_busy = (m_mode != 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (dut_vec() !== {1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 24'd0, 16'd0}) begin
      bad++; $display("FAIL reset got=%h want=%h", dut_vec(), {1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 24'd0, 16'd0});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [23:0] rows [3];
    logic [23:0] r, exp_lane;
    int pos;
    rows[0] = 24'h030201; rows[1] = 24'h060504; rows[2] = 24'h090807;
    for (int n = 0; n < 3; n++) begin
      s_valid = 1'b1; s_data = rows[n]; step();
    end
    s_valid = 1'b0;
    start = 1'b1; row_count = 5'd3; step();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      exp_lane = '0;
      for (int k = 0; k < 3; k++) begin
        pos = i - 2 - k;
        if (pos >= 0 && pos < 3) begin r = rows[pos]; exp_lane[k*8 +: 8] = r[k*8 +: 8]; end
      end
      total++;
      if ({en_o, done_o, lane_o} !== {(i >= 2 && i <= 8), (i == 8), exp_lane}) begin
        bad++; $display("FAIL basic_c%0d en/done/lane got=%b/%b/%h want=%b/%b/%h", i, en_o, done_o, lane_o,
                        (i >= 2 && i <= 8), (i == 8), exp_lane);
      end
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL basic_model_c%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
      step();
    end
  endtask

  task automatic test_stall();
    s_valid = 1'b1; s_data = $urandom; step();
    s_valid = 1'b0;
    start = 1'b1; row_count = 5'd2; step();
    start = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL stall_model_c%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
      s_valid = (i == 6);
      s_data = $urandom;
      step();
    end
    s_valid = 1'b0;
    total++;
`ifdef NPU_FEEDER_STALL_CNT_EN
    if (stall_cnt_o !== 16'd5) begin bad++; $display("FAIL stall_cnt got=%0d want=5", stall_cnt_o); end
`else
    if (stall_cnt_o !== 16'd0) begin bad++; $display("FAIL stall_cnt got=%0d want=0", stall_cnt_o); end
`endif
  endtask

  task automatic test_full();
    for (int n = 0; n < 17; n++) begin
      s_valid = 1'b1; s_data = $urandom; step();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL full_push%0d got=%h want=%h", n, dut_vec(), model_vec());
      end
    end
    total++;
    if ({s_ready, level_o} !== {1'b0, 5'd16}) begin
      bad++; $display("FAIL full_level ready/level got=%b/%0d want=0/16", s_ready, level_o);
    end
    start = 1'b1; row_count = 5'd2; step();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL full_model_c%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
      if (i >= 2 && i <= 4) begin
        total++;
        if (level_o !== ((i == 4) ? 5'd16 : 5'd15)) begin
          bad++; $display("FAIL full_pushpop_c%0d level got=%0d want=%0d", i, level_o, (i == 4) ? 16 : 15);
        end
      end
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset_midrun();
    rst = 1'b1; step(); rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      s_valid = 1'b1; s_data = $urandom; step();
    end
    s_valid = 1'b0;
    start = 1'b1; row_count = 5'd5; step();
    start = 1'b0;
    step();
    total++;
    if ({busy_o, level_o} !== {1'b1, 5'd4}) begin
      bad++; $display("FAIL rst_pre busy/level got=%b/%0d want=1/4", busy_o, level_o);
    end
    rst = 1'b1; step(); rst = 1'b0;
    total++;
    if ({busy_o, level_o, lane_o, done_o, en_o} !== '0) begin
      bad++; $display("FAIL rst_mid busy/level/lane/done got=%b/%0d/%h/%b want=0/0/0/0", busy_o, level_o, lane_o, done_o);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (dut_vec() !== model_vec() || done_o !== 1'b0) begin
        bad++; $display("FAIL rst_after_c%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_zero_rows();
    start = 1'b1; row_count = 5'd0; step();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      total++;
      if ({en_o, done_o} !== {1'b0, (i == 2)}) begin
        bad++; $display("FAIL zero_c%0d en/done got=%b/%b want=0/%b", i, en_o, done_o, (i == 2));
      end
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL zero_model_c%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
      step();
    end
  endtask

  task automatic test_ignored_start();
    for (int n = 0; n < 2; n++) begin
      s_valid = 1'b1; s_data = $urandom; step();
    end
    s_valid = 1'b0;
    start = 1'b1; row_count = 5'd2; step();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      total++;
      if ({done_o, busy_o} !== {(i == 7), (i < 7)}) begin
        bad++; $display("FAIL ign_start_c%0d done/busy got=%b/%b want=%b/%b", i, done_o, busy_o, (i == 7), (i < 7));
      end
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL ign_model_c%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
      start = (i == 2);
      row_count = 5'd7;
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      s_valid   = ($urandom_range(0, 1) == 1);
      s_data    = $urandom;
      start     = ($urandom_range(0, 9) == 0);
      row_count = 5'($urandom_range(0, 12));
      rst       = ($urandom_range(0, 399) == 0);
      step();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL random_c%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
    end
    rst = 1'b0; s_valid = 1'b0; start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_full();
    test_reset_midrun();
    test_zero_rows();
    test_ignored_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
